// File: rtl/moa_8x8_stream_feeder_pkg.sv
// Shared constants and state enumeration for the 8-operand stream feeder.
package moa_8x8_stream_feeder_pkg;

  localparam int unsigned MOA_CORE_LAT = 2;
  localparam int unsigned MOA_N_OPS    = 8;
  localparam int unsigned MOA_OP_W     = 8;
  localparam int unsigned MOA_SUM_W    = 11;
  localparam int unsigned MOA_CNT_W    = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    RESULT  = 2'd2
  } moa_state_e;

endpackage

// File: rtl/moa_8x8p2_rt8_mfa42.sv
// 8-operand unsigned compressor core, two register stages (latency MOA_CORE_LAT).
// Ports: clk, rst_n (async, active-low), x0..x7 operands, summ 11-bit sum.
module moa_8x8p2_rt8_mfa42
  import moa_8x8_stream_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MOA_OP_W-1:0]  x0,
  input  logic [MOA_OP_W-1:0]  x1,
  input  logic [MOA_OP_W-1:0]  x2,
  input  logic [MOA_OP_W-1:0]  x3,
  input  logic [MOA_OP_W-1:0]  x4,
  input  logic [MOA_OP_W-1:0]  x5,
  input  logic [MOA_OP_W-1:0]  x6,
  input  logic [MOA_OP_W-1:0]  x7,
  output logic [MOA_SUM_W-1:0] summ
);

  localparam int unsigned HALF_W = MOA_OP_W + 2;

  logic [HALF_W-1:0] lo_sum;
  logic [HALF_W-1:0] hi_sum;

  // Stage 1: two 4:1 partial sums, 4 x 255 = 1020 fits in 10 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum <= '0;
      hi_sum <= '0;
    end else begin
      lo_sum <= HALF_W'(x0) + HALF_W'(x1) + HALF_W'(x2) + HALF_W'(x3);
      hi_sum <= HALF_W'(x4) + HALF_W'(x5) + HALF_W'(x6) + HALF_W'(x7);
    end
  end

  // Stage 2: final 2:1 add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      summ <= '0;
    end else begin
      summ <= MOA_SUM_W'(lo_sum) + MOA_SUM_W'(hi_sum);
    end
  end

endmodule

// File: rtl/moa_8x8_stream_feeder.sv
// Collects up to eight 8-bit words into an operand bank, waits out the core
// latency, then presents the group sum and operand count with valid/ready.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data/in_last
// producer side; out_valid/out_ready/out_sum/out_count consumer side.
module moa_8x8_stream_feeder
  import moa_8x8_stream_feeder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MOA_OP_W-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MOA_SUM_W-1:0] out_sum,
  output logic [MOA_CNT_W-1:0] out_count
);

  localparam logic [1:0] S_COLLECT = 2'(COLLECT);
  localparam logic [1:0] S_WAIT    = 2'(WAIT);
  localparam logic [1:0] S_RESULT  = 2'(RESULT);

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [MOA_CNT_W-1:0] slot_cnt;
  logic                 wait_cnt;
  logic [MOA_OP_W-1:0]  bank [MOA_N_OPS];
  logic                 accept_c;
  logic                 close_c;
  logic                 take_c;

  assign accept_c = in_valid & in_ready;
  assign close_c  = accept_c & (in_last | (slot_cnt == MOA_CNT_W'(MOA_N_OPS - 1)));
  assign take_c   = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_COLLECT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; WAIT spans MOA_CORE_LAT cycles via the 1-bit counter.
  always_comb begin
    next_state = state;
    case (state)
      S_COLLECT: if (close_c)  next_state = S_WAIT;
      S_WAIT:    if (wait_cnt) next_state = S_RESULT;
      S_RESULT:  if (take_c)   next_state = S_COLLECT;
      default:                 next_state = S_COLLECT;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      wait_cnt  <= 1'b0;
    end else begin
      in_ready  <= (next_state == S_COLLECT);
      out_valid <= (next_state == S_RESULT);
      wait_cnt  <= (state == S_WAIT) ? ~wait_cnt : 1'b0;
    end
  end

  // Operand bank and slot bookkeeping; bank is frozen from close to handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      out_count <= '0;
      for (int i = 0; i < MOA_N_OPS; i++) bank[i] <= '0;
    end else if (take_c) begin
      slot_cnt <= '0;
      for (int i = 0; i < MOA_N_OPS; i++) bank[i] <= '0;
    end else if (accept_c) begin
      bank[slot_cnt[2:0]] <= in_data;
      slot_cnt            <= slot_cnt + MOA_CNT_W'(1);
      if (close_c) out_count <= slot_cnt + MOA_CNT_W'(1);
    end
  end

  moa_8x8p2_rt8_mfa42 u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .x0    (bank[0]),
    .x1    (bank[1]),
    .x2    (bank[2]),
    .x3    (bank[3]),
    .x4    (bank[4]),
    .x5    (bank[5]),
    .x6    (bank[6]),
    .x7    (bank[7]),
    .summ  (out_sum)
  );

endmodule

// File: tb/tb_moa_8x8_stream_feeder.sv
// Self-checking bench for moa_8x8_stream_feeder: directed groups plus
// randomized valid/ready gaps against a queue-free group reference sum.
module tb_moa_8x8_stream_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_sum;
  logic [3:0]  out_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] gw [8];
  int         gn;
  bit         glast8;

  always #5 clk = ~clk;

  moa_8x8_stream_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  // Reference: plain sum of the accepted words; unused slots contribute zero.
  function automatic int ref_sum();
    int s = 0;
    for (int i = 0; i < gn; i++) s += int'(gw[i]);
    return s;
  endfunction

  // Present one word and hold it until the DUT accepts it; returns at the negedge after the accept.
  task automatic send_word(input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", t);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
  endtask

  task automatic send_group(input int gap_max);
    for (int i = 0; i < gn; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
        @(negedge clk);
      end
      send_word(gw[i], 1'((i == gn - 1) && (gn < 8 || glast8)));
    end
  endtask

  // Wait for out_valid, check latency/sum/count, hold off for a random time, then take the result.
  task automatic check_group(input string name, input int hold_max);
    int lat = 1;
    int hold;
    int es = ref_sum();
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat !== 3) $display("FAIL %s_latency: out_valid after %0d cycles, required 3", name, lat);
    else n_pass++;
    n_checks++;
    if (out_sum !== 11'(es)) $display("FAIL %s_sum: got %0d, required %0d", name, out_sum, es);
    else n_pass++;
    n_checks++;
    if (out_count !== 4'(gn)) $display("FAIL %s_count: got %0d, required %0d", name, out_count, gn);
    else n_pass++;
    hold = $urandom_range(0, hold_max);
    out_ready = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 11'(es) || out_count !== 4'(gn))
        $display("FAIL %s_hold: valid=%0b sum=%0d count=%0d, required 1/%0d/%0d",
                 name, out_valid, out_sum, out_count, es, gn);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s_release: valid=%0b in_ready=%0b, required 0/1", name, out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b, required 0", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %0b, required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_full_255();
    gn = 8; glast8 = 1'b0;
    for (int i = 0; i < 8; i++) gw[i] = 8'd255;
    send_group(0);
    check_group("full_255", 0);
    n_checks++;
    if (ref_sum() !== 2040) $display("FAIL full_255_ref: got %0d, required 2040", ref_sum());
    else n_pass++;
  endtask

  task automatic test_last_on_8();
    gn = 8; glast8 = 1'b1;
    for (int i = 0; i < 8; i++) gw[i] = 8'(i + 1);
    send_group(1);
    check_group("last_on_8", 1);
    // A spurious second close would raise out_valid again.
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL last_on_8_single: out_valid=%0b, required 0", out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_short_groups();
    gn = 3; glast8 = 1'b0;
    gw[0] = 8'd10; gw[1] = 8'd20; gw[2] = 8'd30;
    send_group(0);
    check_group("short3", 0);
    gn = 1; gw[0] = 8'd5;
    send_group(0);
    check_group("short1", 0);
  endtask

  task automatic test_backpressure();
    int lat = 1;
    gn = 2; glast8 = 1'b0; gw[0] = 8'd10; gw[1] = 8'd20;
    send_group(0);
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 11'd30 || out_count !== 4'd2 || in_ready !== 1'b0)
        $display("FAIL backpressure_hold: valid=%0b sum=%0d count=%0d in_ready=%0b, required 1/30/2/0",
                 out_valid, out_sum, out_count, in_ready);
      else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL backpressure_release: in_ready=%0b valid=%0b, required 1/0", in_ready, out_valid);
    else n_pass++;
    // The held word 99 must not have entered the bank.
    gn = 1; gw[0] = 8'd7;
    send_group(0);
    check_group("after_backpressure", 0);
  endtask

  task automatic test_reset_in_wait();
    gn = 3; glast8 = 1'b0; gw[0] = 8'd1; gw[1] = 8'd2; gw[2] = 8'd3;
    send_group(0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL reset_wait_no_valid: out_valid=%0b, required 0", out_valid);
      else n_pass++;
    end
    out_ready = 1'b0;
    gn = 8; glast8 = 1'b0;
    for (int i = 0; i < 8; i++) gw[i] = 8'(i + 1);
    send_group(0);
    check_group("after_reset_wait", 0);
  endtask

  task automatic test_random();
    for (int g = 0; g < 1000; g++) begin
      gn = $urandom_range(1, 8);
      glast8 = 1'($urandom);
      for (int i = 0; i < 8; i++) gw[i] = 8'($urandom);
      out_ready = 1'($urandom);
      send_group(2);
      out_ready = 1'($urandom);
      check_group("random", 3);
    end
  endtask

  initial begin
    test_reset();
    test_full_255();
    test_last_on_8();
    test_short_groups();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
